mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one external memory port between the I-cache and the D-cache memory channels.
- Sits between the two caches' memory-side interfaces and the single memory controller port.
- Channel packing is identical to the CPU top's dual-channel memory bus: channel 1 (I-cache) occupies the upper half, channel 0 (D-cache) the lower half, so the block drops in directly.
- Arbitration is round-robin or fixed priority; one outstanding transaction at a time, with an optional response watchdog.

Parameters:
ADDR_WIDTH, 32, address width per channel
DATA_WIDTH, 32, data width per channel
PRIO_MODE, 0, 0 = round-robin; 1 = channel 0 (D-cache) always wins ties
TIMEOUT_CYCLES, 0, ISSUE-state cycles before abort; 0 disables the watchdog

Ports:
clk  input  1  clock; everything sampled on the rising edge
rst  input  1  asynchronous, active-high reset
req_rw_flag  input  4  per channel [2i+1:2i]: 01 = read, 10 = write, 00/11 = no request
req_addr  input  2*ADDR_WIDTH  per-channel address
req_wdata  input  2*DATA_WIDTH  per-channel write data
req_sel  input  8  per-channel byte mask, [4i+3:4i]
req_rdata  output  2*DATA_WIDTH  per-channel read data, registered
req_busy  output  2  per-channel busy
req_done  output  2  per-channel one-cycle completion pulse
mem_rw_flag  output  2  to memory: 01 = read, 10 = write
mem_addr  output  ADDR_WIDTH  to memory
mem_wdata  output  DATA_WIDTH  to memory
mem_sel  output  4  to memory
mem_rdata  input  DATA_WIDTH  from memory; valid when mem_done=1
mem_busy  input  1  memory cannot accept a new request
mem_done  input  1  memory completion pulse
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (asynchronous):
  - state=IDLE; last_grant=1, so channel 0 wins the first tie.
  - timeout counter=0.
  - All registered outputs are 0: mem_rw_flag, mem_addr, mem_wdata, mem_sel, req_rdata, req_done, timeout_err.
  - Reset mid-transaction drops the memory request immediately; no done is issued.
- Valid request on channel i: req_rw_flag[2i+1:2i] is 01 or 10. The value 11 is ignored and never granted.
- Requester contract: hold flag, address, data and mask stable until its req_done pulse; drop the flag on the edge where done is sampled.
- IDLE:
  - When mem_busy=0 and at least one valid request is present, choose grant, latch that channel's flag/address/data/mask into the mem_* registers, and go to ISSUE.
  - With mem_busy=1, grant nothing.
- Grant rule:
  - Single requester: it wins.
  - Both, PRIO_MODE=0: grant = ~last_grant.
  - Both, PRIO_MODE=1: grant = 0.
- ISSUE:
  - mem_rw_flag and the other mem_* outputs are held at the latched values.
  - Timeout counter increments each cycle.
  - On mem_done=1: if a read, req_rdata[grant] <= mem_rdata (other channel's rdata untouched; writes leave rdata unchanged). Clear mem_rw_flag and go to RESP.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without mem_done: clear mem_rw_flag, set the abort flag, go to RESP, rdata unchanged.
  - mem_done in the same cycle as the timeout: the done wins, no error.
- RESP:
  - req_done[grant]=1 for exactly one cycle.
  - timeout_err=1 in this cycle if aborting.
  - last_grant <= grant; counter cleared; next state IDLE.
- req_busy[i] = (state != IDLE) | mem_busy. This is combinational and identical for both channels.
- Latency:
  - Request present at edge t (IDLE) → mem_rw_flag valid from t+1.
  - mem_done sampled at edge u → req_done high during cycle u+1.
  - Minimum request-to-done is 3 cycles; at least one IDLE cycle separates transactions.
- mem_done seen while in IDLE or RESP is ignored.
- req_done is never asserted on both channels simultaneously.

Test Plan:
- Single D read: ch0 flag=01, addr=0x100, sel=0xF; memory returns 0xDEADBEEF two cycles after issue → mem_addr=0x100, mem_rw_flag=01; req_rdata[31:0]=0xDEADBEEF; req_done=2'b01 for one cycle; rdata[63:32] unchanged.
- Simultaneous requests, PRIO_MODE=0: ch0 write 0x200/0x12345678/sel=0x3 and ch1 read 0x40 asserted together → ch0 served first (mem_wdata=0x12345678, mem_sel=0x3), then ch1; grants alternate over 4 back-to-back contested transactions.
- PRIO_MODE=1 with both channels continuously requesting → channel 0 granted every time; channel 1 granted only when channel 0's flag is 00.
- Blocking and invalid flags: mem_busy=1 for 5 cycles with ch1 read pending → mem_rw_flag stays 00 and req_busy=2'b11; grant occurs the cycle after mem_busy falls. Ch0 flag=11 → never granted.
- Watchdog with TIMEOUT_CYCLES=8 and no mem_done → mem_rw_flag drops after 8 ISSUE cycles; req_done and timeout_err pulse together; rdata unchanged. Repeat with mem_done on the 8th cycle → no error.
- Reset pulse during ISSUE → all outputs 0 immediately; after release, a ch0/ch1 tie grants ch0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - dual-channel cache-side bus plus single memory port
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [3:0]              req_rw_flag;
   logic [2*ADDR_WIDTH-1:0] req_addr;
   logic [2*DATA_WIDTH-1:0] req_wdata;
   logic [7:0]              req_sel;
   logic [2*DATA_WIDTH-1:0] req_rdata;
   logic [1:0]              req_busy;
   logic [1:0]              req_done;
   logic [1:0]              mem_rw_flag;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [3:0]              mem_sel;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    mem_busy;
   logic                    mem_done;
   logic                    timeout_err;

   modport master (
      input  req_rw_flag, req_addr, req_wdata, req_sel, mem_rdata, mem_busy, mem_done,
      output req_rdata, req_busy, req_done, mem_rw_flag, mem_addr, mem_wdata, mem_sel,
             timeout_err
   );

   modport slave (
      output req_rw_flag, req_addr, req_wdata, req_sel, mem_rdata, mem_busy, mem_done,
      input  req_rdata, req_busy, req_done, mem_rw_flag, mem_addr, mem_wdata, mem_sel,
             timeout_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between the D-cache (ch0) and I-cache (ch1)
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int PRIO_MODE      = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic                    grant_q, grant_d;
   logic                    last_grant_q, last_grant_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [1:0]              mem_rw_flag_q, mem_rw_flag_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]              mem_sel_q, mem_sel_d;
   logic [2*DATA_WIDTH-1:0] req_rdata_q, req_rdata_d;
   logic [1:0]              req_done_q, req_done_d;
   logic                    timeout_err_q, timeout_err_d;
   logic                    v0, v1, pick;

   // Flag 11 is treated like 00: never a valid request.
   always_comb begin
      v0 = (bus.req_rw_flag[1:0] == 2'b01) || (bus.req_rw_flag[1:0] == 2'b10);
      v1 = (bus.req_rw_flag[3:2] == 2'b01) || (bus.req_rw_flag[3:2] == 2'b10);
      if (v0 && v1) begin
         pick = (PRIO_MODE != 0) ? 1'b0 : ~last_grant_q;
      end else begin
         pick = v1;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      cnt_d         = cnt_q;
      mem_rw_flag_d = mem_rw_flag_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_sel_d     = mem_sel_q;
      req_rdata_d   = req_rdata_q;
      req_done_d    = 2'b00;
      timeout_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.mem_busy && (v0 || v1)) begin
               grant_d       = pick;
               mem_rw_flag_d = pick ? bus.req_rw_flag[3:2] : bus.req_rw_flag[1:0];
               mem_addr_d    = pick ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : bus.req_addr[ADDR_WIDTH-1:0];
               mem_wdata_d   = pick ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : bus.req_wdata[DATA_WIDTH-1:0];
               mem_sel_d     = pick ? bus.req_sel[7:4] : bus.req_sel[3:0];
               cnt_d         = '0;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            // A completion in the same cycle as the watchdog expiry takes precedence.
            if (bus.mem_done) begin
               if (mem_rw_flag_q == 2'b01) begin
                  if (grant_q) begin
                     req_rdata_d[2*DATA_WIDTH-1:DATA_WIDTH] = bus.mem_rdata;
                  end else begin
                     req_rdata_d[DATA_WIDTH-1:0] = bus.mem_rdata;
                  end
               end
               mem_rw_flag_d = 2'b00;
               req_done_d    = grant_q ? 2'b10 : 2'b01;
               state_d       = RESP;
            end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == TMO_LAST)) begin
               mem_rw_flag_d = 2'b00;
               req_done_d    = grant_q ? 2'b10 : 2'b01;
               timeout_err_d = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            last_grant_d = grant_q;
            cnt_d        = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         cnt_q         <= '0;
         mem_rw_flag_q <= 2'b00;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_sel_q     <= 4'h0;
         req_rdata_q   <= '0;
         req_done_q    <= 2'b00;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         mem_rw_flag_q <= mem_rw_flag_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_sel_q     <= mem_sel_d;
         req_rdata_q   <= req_rdata_d;
         req_done_q    <= req_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.req_busy    = {2{(state_q != IDLE) | bus.mem_busy}};
   assign bus.req_rdata   = req_rdata_q;
   assign bus.req_done    = req_done_q;
   assign bus.mem_rw_flag = mem_rw_flag_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_sel     = mem_sel_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized transaction-level check of mem_arbiter
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_rw_flag;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_sel;
   logic [31:0] mem_rdata;
   logic        mem_busy, mem_done;
   logic        dsel;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

   assign bus_a.req_rw_flag = req_rw_flag;
   assign bus_a.req_addr    = req_addr;
   assign bus_a.req_wdata   = req_wdata;
   assign bus_a.req_sel     = req_sel;
   assign bus_a.mem_rdata   = mem_rdata;
   assign bus_a.mem_busy    = mem_busy;
   assign bus_a.mem_done    = mem_done;
   assign bus_b.req_rw_flag = req_rw_flag;
   assign bus_b.req_addr    = req_addr;
   assign bus_b.req_wdata   = req_wdata;
   assign bus_b.req_sel     = req_sel;
   assign bus_b.mem_rdata   = mem_rdata;
   assign bus_b.mem_busy    = mem_busy;
   assign bus_b.mem_done    = mem_done;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(1), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   logic [63:0] o_req_rdata;
   logic [1:0]  o_req_busy, o_req_done, o_mem_rw_flag;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_sel;
   logic        o_timeout_err;

   assign o_req_rdata   = dsel ? bus_b.req_rdata   : bus_a.req_rdata;
   assign o_req_busy    = dsel ? bus_b.req_busy    : bus_a.req_busy;
   assign o_req_done    = dsel ? bus_b.req_done    : bus_a.req_done;
   assign o_mem_rw_flag = dsel ? bus_b.mem_rw_flag : bus_a.mem_rw_flag;
   assign o_mem_addr    = dsel ? bus_b.mem_addr    : bus_a.mem_addr;
   assign o_mem_wdata   = dsel ? bus_b.mem_wdata   : bus_a.mem_wdata;
   assign o_mem_sel     = dsel ? bus_b.mem_sel     : bus_a.mem_sel;
   assign o_timeout_err = dsel ? bus_b.timeout_err : bus_a.timeout_err;

   // Reference model: requester state, last winner and per-channel read data.
   logic [1:0]  m_flag  [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_sel   [2];
   logic [31:0] m_rdata [2];
   int          m_last;
   int          prio, tmo;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_valid(input logic [1:0] f);
      return (f == 2'b01) || (f == 2'b10);
   endfunction

   function automatic int exp_grant();
      bit a, b;
      a = is_valid(m_flag[0]);
      b = is_valid(m_flag[1]);
      if (!a && !b) return -1;
      if (a && !b)  return 0;
      if (b && !a)  return 1;
      if (prio != 0) return 0;
      return (m_last == 0) ? 1 : 0;
   endfunction

   task automatic drive_reqs();
      req_rw_flag = {m_flag[1], m_flag[0]};
      req_addr    = {m_addr[1], m_addr[0]};
      req_wdata   = {m_wdata[1], m_wdata[0]};
      req_sel     = {m_sel[1], m_sel[0]};
   endtask

   task automatic set_req(input int ch, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      m_flag[ch] = f; m_addr[ch] = a; m_wdata[ch] = d; m_sel[ch] = s;
      drive_reqs();
   endtask

   task automatic new_req(input int ch);
      set_req(ch, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, $urandom, $urandom,
              4'($urandom_range(1, 15)));
   endtask

   task automatic randomize_idle();
      int r;
      for (int ch = 0; ch < 2; ch++) begin
         if (!is_valid(m_flag[ch])) begin
            r = $urandom_range(0, 9);
            set_req(ch, (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00,
                    $urandom, $urandom, 4'($urandom_range(0, 15)));
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_flag"},  o_mem_rw_flag, 0);
      chk({tag, "_addr"},  o_mem_addr, 0);
      chk({tag, "_wdata"}, o_mem_wdata, 0);
      chk({tag, "_sel"},   o_mem_sel, 0);
      chk({tag, "_rdata"}, o_req_rdata, 0);
      chk({tag, "_done"},  o_req_done, 0);
      chk({tag, "_tmo"},   o_timeout_err, 0);
      chk({tag, "_busy"},  o_req_busy, 0);
   endtask

   task automatic model_reset();
      m_last = 1;
      m_rdata[0] = 0;
      m_rdata[1] = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_req(0, 2'b00, 0, 0, 0);
      set_req(1, 2'b00, 0, 0, 0);
      mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = 0;
      @(posedge clk); #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      model_reset();
   endtask

   // One arbitration round starting in an IDLE cycle, ending in the next IDLE cycle.
   task automatic round(input int busy_cyc, input int delay, input bit give_done,
                        input logic [31:0] rdat, input bit renew);
      int g, len;
      bit ab;
      for (int i = 0; i < busy_cyc; i++) begin
         mem_busy = 1'b1;
         #1;
         chk("blocked_busy", o_req_busy, 2'b11);
         @(posedge clk); #1;
         chk("blocked_no_issue", o_mem_rw_flag, 0);
      end
      mem_busy  = 1'b0;
      g         = exp_grant();
      mem_done  = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(posedge clk); #1;
      if (g < 0) begin
         mem_done = 1'b0;
         chk("nogrant_flag", o_mem_rw_flag, 0);
         chk("nogrant_busy", o_req_busy, 0);
         return;
      end
      ab  = (tmo > 0) && (!give_done || delay > tmo);
      len = ab ? tmo : delay;
      for (int k = 0; k < len; k++) begin
         chk("issue_flag",  o_mem_rw_flag, m_flag[g]);
         chk("issue_addr",  o_mem_addr, m_addr[g]);
         chk("issue_wdata", o_mem_wdata, m_wdata[g]);
         chk("issue_sel",   o_mem_sel, m_sel[g]);
         chk("issue_busy",  o_req_busy, 2'b11);
         chk("issue_done",  o_req_done, 0);
         chk("issue_tmo",   o_timeout_err, 0);
         mem_done  = give_done && !ab && (k == len - 1);
         mem_rdata = mem_done ? rdat : $urandom;
         @(posedge clk); #1;
      end
      if (!ab && m_flag[g] == 2'b01) m_rdata[g] = rdat;
      mem_done  = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      chk("resp_flag",  o_mem_rw_flag, 0);
      chk("resp_done",  o_req_done, (g != 0) ? 2'b10 : 2'b01);
      chk("resp_tmo",   o_timeout_err, ab);
      chk("resp_rdata", o_req_rdata, {m_rdata[1], m_rdata[0]});
      chk("resp_busy",  o_req_busy, 2'b11);
      m_last = g;
      if (renew) new_req(g);
      else set_req(g, 2'b00, 0, 0, 0);
      @(posedge clk); #1;
      mem_done = 1'b0;
      chk("idle_done", o_req_done, 0);
      chk("idle_tmo",  o_timeout_err, 0);
      chk("idle_flag", o_mem_rw_flag, 0);
      chk("idle_busy", o_req_busy, 0);
      chk("idle_rdata", o_req_rdata, {m_rdata[1], m_rdata[0]});
   endtask

   initial begin
      int g;
      dsel = 1'b0; prio = 0; tmo = 8;
      rst = 1'b1;
      m_flag[0] = 0; m_flag[1] = 0;
      set_req(0, 2'b00, 0, 0, 0);
      set_req(1, 2'b00, 0, 0, 0);
      mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      model_reset();

      // Single D-cache read
      set_req(0, 2'b01, 32'h100, 32'h0, 4'hF);
      round(0, 2, 1'b1, 32'hDEADBEEF, 1'b0);

      // Contested round-robin from a fresh reset: ch0 first, then alternate
      do_reset();
      set_req(0, 2'b10, 32'h200, 32'h12345678, 4'h3);
      set_req(1, 2'b01, 32'h40, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) round(0, 1 + i, 1'b1, $urandom, 1'b1);
      round(0, 2, 1'b1, $urandom, 1'b0);
      round(0, 2, 1'b1, $urandom, 1'b0);

      // Memory busy blocks the grant; then an invalid flag is never served
      set_req(1, 2'b01, 32'h80, 32'h0, 4'hF);
      round(5, 1, 1'b1, 32'hCAFEF00D, 1'b0);
      set_req(0, 2'b11, 32'h300, 32'h1, 4'h1);
      for (int i = 0; i < 3; i++) round(0, 1, 1'b1, 0, 1'b0);
      set_req(1, 2'b01, 32'h84, 32'h0, 4'hF);
      round(0, 3, 1'b1, 32'h0BADC0DE, 1'b0);
      set_req(0, 2'b00, 0, 0, 0);

      // Watchdog: abort after 8 ISSUE cycles; done on the 8th cycle wins
      set_req(0, 2'b01, 32'h500, 32'h0, 4'hF);
      round(0, 0, 1'b0, 0, 1'b0);
      set_req(1, 2'b01, 32'h504, 32'h0, 4'hF);
      round(0, 8, 1'b1, 32'h13572468, 1'b0);
      set_req(0, 2'b01, 32'h508, 32'h0, 4'hF);
      round(0, 9, 1'b1, 32'h99999999, 1'b0);

      for (int i = 0; i < 60; i++) begin
         randomize_idle();
         round($urandom_range(0, 2), $urandom_range(1, 10), $urandom_range(0, 5) != 0,
               $urandom, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of an ISSUE phase
      do_reset();
      set_req(0, 2'b01, 32'h600, 32'h0, 4'hF);
      set_req(1, 2'b10, 32'h604, 32'h77, 4'hC);
      g = exp_grant();
      @(posedge clk); #1;
      chk("pre_reset_flag", o_mem_rw_flag, m_flag[g]);
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      round(0, 2, 1'b1, 32'h2468ACE0, 1'b1);

      // Fixed-priority instance, watchdog disabled
      dsel = 1'b1; prio = 1; tmo = 0;
      do_reset();
      new_req(0);
      new_req(1);
      for (int i = 0; i < 4; i++) round(0, $urandom_range(1, 4), 1'b1, $urandom, 1'b1);
      round(0, 2, 1'b1, $urandom, 1'b0);
      round(0, 2, 1'b1, $urandom, 1'b0);
      set_req(0, 2'b01, 32'h700, 32'h0, 4'hF);
      round(0, 20, 1'b1, 32'h31415926, 1'b0);
      for (int i = 0; i < 40; i++) begin
         randomize_idle();
         round($urandom_range(0, 2), $urandom_range(1, 10), 1'b1, $urandom,
               1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
